sync_cmd_scheduler: RTL and testbench
=====================================

Name: sync_cmd_scheduler

Overview:
Frame-based command scheduler for the serial reset/sync line that the sync board drives to all backends. It arbitrates between NREQ command requesters and an internal periodic timestamp-sync generator. It serializes one FRAME_BITS-wide code per frame, MSB first, on ser_out, and inserts the idle code whenever no command is scheduled. ser_out feeds the per-backend same-edge ODDR/OBUFDS reset outputs.

Parameters:
NREQ, 2, number of external command requesters (1..8)
FRAME_BITS, 4, bits per frame and per code
IDLE_CODE, 4'b1010, code sent when no command is scheduled
SYNC_CODE, 4'b1110, code sent by the internal periodic sync
SYNC_PERIOD, 100000000, clk cycles between periodic syncs; 0 disables the generator
GAP_FRAMES, 1, forced idle frames after every command frame (0..15)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
sync_en  in  1  enables the periodic sync generator
req_valid  in  NREQ  per-requester command valid
req_code  in  NREQ*FRAME_BITS  per-requester code; requester i uses slice [i*FRAME_BITS +: FRAME_BITS]
req_ready  out  NREQ  one-cycle grant/accept pulse
ser_out  out  1  serial line, MSB of the shift register
frame_start  out  1  high during the first bit cycle of every frame
busy  out  1  high while a command or gap frame is being sent
sync_overrun  out  1  sticky flag: periodic sync fired while the previous one was still pending
cmd_count  out  16  number of command frames sent, including syncs; wraps

Behaviour:
- Reset values: shift_reg=IDLE_CODE, bit_cnt=0, state=S_IDLE, rr_ptr=0, period counter=0, sync_pending=0, gap_cnt=0. Outputs after reset: ser_out=IDLE_CODE MSB (1), frame_start=1, busy=0, sync_overrun=0, cmd_count=0, req_ready=0.
- Reset mid-frame aborts the frame immediately. Any un-acked request stays unacked.
- Framing: bit_cnt counts 0..FRAME_BITS-1 and wraps. ser_out=shift_reg[FRAME_BITS-1]. frame_start=(bit_cnt==0).
  - When bit_cnt!=FRAME_BITS-1: shift_reg shifts left by 1.
  - When bit_cnt==FRAME_BITS-1 (the "load cycle"): shift_reg loads the next frame code.
- Load-cycle decision, in priority order:
  - state==S_GAP and gap_cnt!=0: load IDLE_CODE, decrement gap_cnt; at 0, go to S_IDLE.
  - sync_pending: load SYNC_CODE, clear sync_pending, go to S_CMD.
  - any req_valid: round-robin grant starting at rr_ptr. Load that requester's req_code, pulse its req_ready for exactly this cycle, set rr_ptr=grant+1 mod NREQ, go to S_CMD.
  - otherwise: load IDLE_CODE, go to S_IDLE.
- Leaving S_CMD: at its load cycle, if GAP_FRAMES>0, state becomes S_GAP and gap_cnt=GAP_FRAMES-1, loading IDLE_CODE. If GAP_FRAMES=0, the decision above applies directly.
- busy=1 in S_CMD and S_GAP.
- cmd_count increments on each command load (sync or requester).
- Handshake: transfer occurs when req_valid&req_ready. The code is sampled in that cycle. Requesters hold valid and code stable until ready. req_ready is never asserted outside a load cycle, and at most one bit is high.
- Latency: request valid at or before load cycle L → ready at L → code MSB on ser_out at L+1 → last bit at L+FRAME_BITS.
- Periodic sync: while sync_en=1 and SYNC_PERIOD!=0, the counter increments each cycle. At SYNC_PERIOD-1 it wraps to 0 and sets sync_pending. If sync_pending is already set at that point, sync_overrun is set instead; sync_overrun clears only on rst. While sync_en=0, the counter is held at 0 and sync_pending is cleared.
- Simultaneous sync wrap and load consuming sync_pending: the load clears pending and the wrap sets it again. Net pending=1 and no overrun.
- Codes equal to IDLE_CODE from requesters are transmitted unchanged but still count as commands (busy, gap, cmd_count).

Test Plan:
- Reset release, no requests, sync_en=0 → ser_out repeats 1,0,1,0. frame_start high at cycles 0,4,8. busy=0, cmd_count=0.
- req_valid[0]=1 with code 4'b1100 at cycle 1 → req_ready[0] pulses at cycle 3. ser_out=1,1,0,0 at cycles 4-7, then one idle frame 1,0,1,0 at cycles 8-11 (GAP_FRAMES=1). cmd_count=1.
- req_valid=2'b11 held continuously with codes 4'b1100 and 4'b1001 → grants alternate 0,1,0,1 on every second load cycle (cycles 3,11,19,27). No cycle has both ready bits set.
- SYNC_PERIOD=20, sync_en=1, req_valid[1] held → SYNC_CODE 1110 is sent before requester 1 whenever both are eligible on the same load cycle. sync_overrun stays 0.
- SYNC_PERIOD=4, GAP_FRAMES=3 → sync fires again while pending, so sync_overrun=1 and it stays set until rst.
- rst asserted at bit 2 of a command frame → next cycle ser_out=1, busy=0, bit_cnt=0. The un-acked requester is granted on the first load cycle after reset release.

Source files
------------

// File: rtl/sync_cmd_scheduler_if.sv
// Command request bus between requesters and the sync-line scheduler.
// Requester i owns req_valid[i], req_code[i*FRAME_BITS +: FRAME_BITS] and req_ready[i].
interface sync_cmd_scheduler_if #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned FRAME_BITS = 4
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*FRAME_BITS-1:0] req_code;
  logic [NREQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_code,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    output req_ready
  );

endinterface

// File: rtl/sync_cmd_scheduler.sv
// Frame-based scheduler for the serial reset/sync line: arbitrates requesters and a periodic
// sync generator, serialising one code per frame MSB first with idle fill between commands.
module sync_cmd_scheduler #(
  parameter int unsigned           NREQ        = 2,
  parameter int unsigned           FRAME_BITS  = 4,
  parameter logic [FRAME_BITS-1:0] IDLE_CODE   = 4'b1010,
  parameter logic [FRAME_BITS-1:0] SYNC_CODE   = 4'b1110,
  parameter int unsigned           SYNC_PERIOD = 100000000,
  parameter int unsigned           GAP_FRAMES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_en,
  sync_cmd_scheduler_if.slave      req,
  output logic                     ser_out,
  output logic                     frame_start,
  output logic                     busy,
  output logic                     sync_overrun,
  output logic [15:0]              cmd_count
);

  localparam int unsigned CntW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PerW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int unsigned GapW = 4;

  localparam logic [CntW-1:0] LastBit  = CntW'(FRAME_BITS - 1);
  localparam logic [PtrW-1:0] LastReq  = PtrW'(NREQ - 1);
  localparam logic [PerW-1:0] PerLast  = PerW'(SYNC_PERIOD - 1);
  localparam logic [GapW-1:0] GapStart = GapW'(GAP_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StGap
  } state_e;

  state_e                state_q, state_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PerW-1:0]       per_cnt_q, per_cnt_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           cmd_count_q, cmd_count_d;

  logic                  load;
  logic                  take_sync;
  logic                  take_req;
  logic                  grant_found;
  logic [PtrW-1:0]       grant_idx;
  logic [FRAME_BITS-1:0] grant_code;

  assign load = (bit_cnt_q == LastBit);

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    int unsigned     sum;
    logic [PtrW-1:0] idx;
    sum         = 0;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = PtrW'(sum);
      if (!grant_found && req.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    grant_code = IDLE_CODE;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == PtrW'(i)) begin
        grant_code = req.req_code[i*FRAME_BITS +: FRAME_BITS];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state: the frame decision is only taken on the load cycle.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    take_sync = 1'b0;
    take_req  = 1'b0;
    if (load) begin
      if (state_q == StCmd && GAP_FRAMES > 0) begin
        state_d   = StGap;
        gap_cnt_d = GapStart;
      end else if (state_q == StGap && gap_cnt_q != '0) begin
        // Stay in StGap; the frame after the last gap frame falls through to arbitration.
        gap_cnt_d = gap_cnt_q - GapW'(1);
      end else if (pending_q) begin
        take_sync = 1'b1;
        state_d   = StCmd;
      end else if (grant_found) begin
        take_req  = 1'b1;
        state_d   = StCmd;
      end else begin
        state_d   = StIdle;
      end
    end
  end

  // Outputs
  always_comb begin
    ser_out       = shift_q[FRAME_BITS-1];
    frame_start   = (bit_cnt_q == '0);
    busy          = (state_q == StCmd) || (state_q == StGap);
    sync_overrun  = overrun_q;
    cmd_count     = cmd_count_q;
    req.req_ready = '0;
    if (take_req) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_idx == PtrW'(i)) begin
          req.req_ready[i] = 1'b1;
        end
      end
    end
  end

  // Serialiser, arbitration pointer and command counter
  always_comb begin
    bit_cnt_d   = load ? '0 : bit_cnt_q + CntW'(1);
    shift_d     = shift_q << 1;
    rr_ptr_d    = rr_ptr_q;
    cmd_count_d = cmd_count_q;
    if (load) begin
      if (take_sync) begin
        shift_d = SYNC_CODE;
      end else if (take_req) begin
        shift_d = grant_code;
      end else begin
        shift_d = IDLE_CODE;
      end
    end
    if (take_req) begin
      rr_ptr_d = (grant_idx == LastReq) ? '0 : grant_idx + PtrW'(1);
    end
    if (take_sync || take_req) begin
      cmd_count_d = cmd_count_q + 16'd1;
    end
  end

  // Periodic sync generator. A wrap coinciding with consumption re-arms pending without overrun.
  always_comb begin
    per_cnt_d = per_cnt_q;
    pending_d = pending_q && !take_sync;
    overrun_d = overrun_q;
    if (SYNC_PERIOD == 0 || !sync_en) begin
      per_cnt_d = '0;
      pending_d = 1'b0;
    end else if (per_cnt_q == PerLast) begin
      per_cnt_d = '0;
      pending_d = 1'b1;
      if (pending_q && !take_sync) begin
        overrun_d = 1'b1;
      end
    end else begin
      per_cnt_d = per_cnt_q + PerW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= IDLE_CODE;
      bit_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      per_cnt_q   <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      per_cnt_q   <= per_cnt_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      cmd_count_q <= cmd_count_d;
    end
  end

endmodule

// File: tb/tb_sync_cmd_scheduler.sv
// Self-checking bench for sync_cmd_scheduler: expected frames are queued when stimulus is
// driven and compared as each frame completes on the serial line.
module tb_sync_cmd_scheduler;

  localparam int unsigned NREQ = 2;
  localparam int unsigned FB   = 4;
  localparam logic [3:0] IDLE = 4'b1010;
  localparam logic [3:0] SYNC = 4'b1110;
  localparam logic [3:0] C0   = 4'b1100;
  localparam logic [3:0] C1   = 4'b1001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_en = 1'b0;
  logic        sync_en_1 = 1'b0;
  logic        ser_out, frame_start, busy, sync_overrun;
  logic [15:0] cmd_count;
  logic        ser_out_1, frame_start_1, busy_1, sync_overrun_1;
  logic [15:0] cmd_count_1;

  always #5 clk = ~clk;

  sync_cmd_scheduler_if #(.NREQ(NREQ), .FRAME_BITS(FB)) bus0 ();
  sync_cmd_scheduler_if #(.NREQ(NREQ), .FRAME_BITS(FB)) bus1 ();

  sync_cmd_scheduler #(
    .NREQ(NREQ), .FRAME_BITS(FB), .IDLE_CODE(IDLE), .SYNC_CODE(SYNC),
    .SYNC_PERIOD(20), .GAP_FRAMES(1)
  ) dut0 (
    .clk(clk), .rst(rst), .sync_en(sync_en), .req(bus0.slave),
    .ser_out(ser_out), .frame_start(frame_start), .busy(busy),
    .sync_overrun(sync_overrun), .cmd_count(cmd_count)
  );

  sync_cmd_scheduler #(
    .NREQ(NREQ), .FRAME_BITS(FB), .IDLE_CODE(IDLE), .SYNC_CODE(SYNC),
    .SYNC_PERIOD(4), .GAP_FRAMES(3)
  ) dut1 (
    .clk(clk), .rst(rst), .sync_en(sync_en_1), .req(bus1.slave),
    .ser_out(ser_out_1), .frame_start(frame_start_1), .busy(busy_1),
    .sync_overrun(sync_overrun_1), .cmd_count(cmd_count_1)
  );

  typedef struct packed {
    logic [3:0] code;
    logic [1:0] ready;
    logic       busy;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         nbit = 0;
  logic [3:0] shreg = '0;
  logic [1:0] pend_clr = '0;
  bit         hold_valid = 1'b0;

  function automatic frame_exp_t fe(input logic [3:0] c, input logic [1:0] r, input logic b);
    fe = '{code: c, ready: r, busy: b};
  endfunction

  // Samples dut0 for the current cycle; each frame's entry is checked on its load cycle.
  task automatic sample();
    logic [1:0] rdy;
    logic       fs_exp;
    frame_exp_t e;
    rdy    = bus0.req_ready;
    fs_exp = (cyc % 4 == 0);
    n_cmp++;
    if (frame_start !== fs_exp) begin
      n_fail++;
      $display("FAIL frame_start cyc=%0d: got %b want %b", cyc, frame_start, fs_exp);
    end
    n_cmp++;
    if ($countones(rdy) > 1) begin
      n_fail++;
      $display("FAIL ready_onehot cyc=%0d: got %b want at most one bit", cyc, rdy);
    end
    if (cyc % 4 != 3) begin
      n_cmp++;
      if (rdy !== 2'b00) begin
        n_fail++;
        $display("FAIL ready_off_load cyc=%0d: got %b want 00", cyc, rdy);
      end
    end
    shreg = {shreg[2:0], ser_out};
    nbit++;
    if (nbit == 4) begin
      nbit = 0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = fe(IDLE, 2'b00, 1'b0);
      n_cmp++;
      if (shreg !== e.code) begin
        n_fail++;
        $display("FAIL frame_code cyc=%0d: got %b want %b", cyc, shreg, e.code);
      end
      n_cmp++;
      if (rdy !== e.ready) begin
        n_fail++;
        $display("FAIL load_ready cyc=%0d: got %b want %b", cyc, rdy, e.ready);
      end
      n_cmp++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL frame_busy cyc=%0d: got %b want %b", cyc, busy, e.busy);
      end
    end
    // Requesters drop valid one cycle after the accepting edge.
    if (!hold_valid) bus0.req_valid = bus0.req_valid & ~pend_clr;
    pend_clr = hold_valid ? 2'b00 : rdy;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Holds reset for three cycles, checks reset outputs, then releases into cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check1("rst_ser_out", ser_out, 1'b1);
    check1("rst_frame_start", frame_start, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_overrun", sync_overrun, 1'b0);
    check1("rst_overrun_1", sync_overrun_1, 1'b0);
    check16("rst_cmd_count", cmd_count, 16'd0);
    check16("rst_req_ready", {14'd0, bus0.req_ready}, 16'd0);
    cyc      = 0;
    nbit     = 0;
    pend_clr = '0;
    sample();
    rst = 1'b0;
  endtask

  task automatic test_reset_idle();
    hold_valid     = 1'b0;
    bus0.req_valid = '0;
    do_reset();
    repeat (11) tick();
    check16("idle_cmd_count", cmd_count, 16'd0);
    check1("idle_busy", busy, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    tick();
    bus0.req_code  = {C1, C0};
    bus0.req_valid = 2'b01;
    exp_q.push_back(fe(IDLE, 2'b01, 1'b0));
    exp_q.push_back(fe(C0, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b00, 1'b0));
    repeat (14) tick();
    check16("single_cmd_count", cmd_count, 16'd1);
  endtask

  task automatic test_round_robin();
    do_reset();
    hold_valid     = 1'b1;
    bus0.req_code  = {C1, C0};
    bus0.req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(fe(IDLE, 2'b01, (k != 0)));
      exp_q.push_back(fe(C0, 2'b00, 1'b1));
      exp_q.push_back(fe(IDLE, 2'b10, 1'b1));
      exp_q.push_back(fe(C1, 2'b00, 1'b1));
    end
    repeat (29) tick();
    bus0.req_valid = 2'b00;
    hold_valid     = 1'b0;
    repeat (2) tick();
    check16("rr_cmd_count", cmd_count, 16'd4);
  endtask

  task automatic test_sync_priority();
    sync_en = 1'b1;
    do_reset();
    hold_valid     = 1'b1;
    bus0.req_code  = {C1, C0};
    bus0.req_valid = 2'b10;
    exp_q.push_back(fe(IDLE, 2'b10, 1'b0));
    exp_q.push_back(fe(C1, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b10, 1'b1));
    exp_q.push_back(fe(C1, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b10, 1'b1));
    exp_q.push_back(fe(C1, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b00, 1'b1));
    exp_q.push_back(fe(SYNC, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b10, 1'b1));
    exp_q.push_back(fe(C1, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b00, 1'b1));
    exp_q.push_back(fe(SYNC, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b10, 1'b1));
    repeat (51) tick();
    check1("prio_overrun", sync_overrun, 1'b0);
    check16("prio_cmd_count", cmd_count, 16'd6);
    sync_en        = 1'b0;
    bus0.req_valid = 2'b00;
    hold_valid     = 1'b0;
  endtask

  task automatic test_overrun();
    sync_en_1 = 1'b1;
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      tick();
      check1($sformatf("overrun_cyc%0d", c), sync_overrun_1, (c >= 12));
    end
    sync_en_1 = 1'b0;
    repeat (4) tick();
    check1("overrun_sticky", sync_overrun_1, 1'b1);
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold_valid     = 1'b0;
    bus0.req_code  = {C1, C0};
    bus0.req_valid = 2'b11;
    exp_q.push_back(fe(IDLE, 2'b01, 1'b0));
    exp_q.push_back(fe(C0, 2'b00, 1'b1));
    repeat (6) tick();
    rst = 1'b1;
    @(negedge clk);
    check1("mid_ser_out", ser_out, 1'b1);
    check1("mid_busy", busy, 1'b0);
    check1("mid_frame_start", frame_start, 1'b1);
    check16("mid_cmd_count", cmd_count, 16'd0);
    exp_q.delete();
    cyc      = 0;
    nbit     = 0;
    pend_clr = '0;
    sample();
    rst = 1'b0;
    exp_q.push_back(fe(IDLE, 2'b10, 1'b0));
    exp_q.push_back(fe(C1, 2'b00, 1'b1));
    exp_q.push_back(fe(IDLE, 2'b00, 1'b1));
    repeat (11) tick();
    check16("mid_after_cmd_count", cmd_count, 16'd1);
  endtask

  initial begin
    bus0.req_valid = '0;
    bus0.req_code  = {C1, C0};
    bus1.req_valid = '0;
    bus1.req_code  = '0;
    test_reset_idle();
    test_single();
    test_round_robin();
    test_sync_priority();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
